// File: rtl/bt_uart_tx.sv
// bt_uart_tx: FIFO-buffered 8-N-1 / 8-E-1 serial transmitter for the Bluetooth
// module. One bit per rising edge of the divided baud level clk_div, which is
// edge-detected in the clk_in domain rather than used as a clock.
// Optional feature macro: BT_UART_TX_PARITY_EN (adds an even-parity bit).
module bt_uart_tx #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          clk_div,
  input  logic                          wr_en,
  input  logic [DATA_BITS-1:0]          wr_data,
  output logic                          full,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          busy,
  output logic                          tx
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] LVL_ALMOST = LW'(FIFO_DEPTH - 1);
  localparam logic [2:0]    BIT_LAST   = 3'(DATA_BITS - 1);
  localparam logic          STOP_LAST  = 1'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               state;
  logic [DATA_BITS-1:0] shift;
  logic [2:0]           bitcnt;
  logic                 stopcnt;
  logic                 clk_div_q;
  logic                 tick;
  logic                 push;
  logic                 pop;
  logic [AW-1:0]        wr_ptr;
  logic [AW-1:0]        rd_ptr;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] rd_data;
`ifdef BT_UART_TX_PARITY_EN
  logic                 par;
`endif

  // clk_div_q resets high so a divider already high at reset release is not a tick
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) clk_div_q <= 1'b1;
    else        clk_div_q <= clk_div;

  assign tick    = clk_div & ~clk_div_q;
  assign push    = wr_en & ~full;
  assign pop     = tick & (level != '0) &
                   ((state == S_IDLE) | ((state == S_STOP) & (stopcnt == STOP_LAST)));
  assign rd_data = mem[rd_ptr];

  // FIFO storage; no reset needed, occupancy is tracked by the pointers
  always_ff @(posedge clk_in)
    if (push) mem[wr_ptr] <= wr_data;

  // FIFO pointers, occupancy, registered full and sticky overflow
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      level    <= '0;
      full     <= 1'b0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) begin
        level <= level + 1'b1;
        full  <= (level == LVL_ALMOST);
      end else if (pop && !push) begin
        level <= level - 1'b1;
        full  <= 1'b0;
      end
      if (wr_en && full) overflow <= 1'b1;
    end

  // Frame FSM; tx and busy are registered and only move on ticks
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      state   <= S_IDLE;
      tx      <= 1'b1;
      busy    <= 1'b0;
      shift   <= '0;
      bitcnt  <= '0;
      stopcnt <= 1'b0;
`ifdef BT_UART_TX_PARITY_EN
      par     <= 1'b0;
`endif
    end else if (tick) begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            shift <= rd_data;
`ifdef BT_UART_TX_PARITY_EN
            par   <= ^rd_data;
`endif
            tx    <= 1'b0;
            busy  <= 1'b1;
            state <= S_START;
          end
        end
        S_START: begin
          tx     <= shift[0];
          bitcnt <= '0;
          state  <= S_DATA;
        end
        S_DATA: begin
          if (bitcnt == BIT_LAST) begin
`ifdef BT_UART_TX_PARITY_EN
            tx      <= par;
            state   <= S_PARITY;
`else
            tx      <= 1'b1;
            stopcnt <= 1'b0;
            state   <= S_STOP;
`endif
          end else begin
            shift  <= shift >> 1;
            bitcnt <= bitcnt + 1'b1;
            tx     <= shift[1];
          end
        end
`ifdef BT_UART_TX_PARITY_EN
        S_PARITY: begin
          tx      <= 1'b1;
          stopcnt <= 1'b0;
          state   <= S_STOP;
        end
`endif
        S_STOP: begin
          if (stopcnt != STOP_LAST) begin
            stopcnt <= stopcnt + 1'b1;
          end else if (pop) begin
            // next byte queued: start bit follows the last stop bit directly
            shift <= rd_data;
`ifdef BT_UART_TX_PARITY_EN
            par   <= ^rd_data;
`endif
            tx    <= 1'b0;
            state <= S_START;
          end else begin
            busy  <= 1'b0;
            state <= S_IDLE;
          end
        end
        default: begin
          tx    <= 1'b1;
          busy  <= 1'b0;
          state <= S_IDLE;
        end
      endcase
    end

endmodule

// File: tb/tb_bt_uart_tx.sv
// tb_bt_uart_tx: directed bench for bt_uart_tx (STOP_BITS=2, FIFO_DEPTH=4).
// clk_div is a 20-cycle square wave; tx is sampled mid-bit on clk_in negedges.
module tb_bt_uart_tx;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       clk_div = 1'b0;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       overflow;
  logic [2:0] level;
  logic       busy;
  logic       tx;

  int n_vec = 0;
  int n_err = 0;

  bt_uart_tx #(.DATA_BITS(8), .STOP_BITS(2), .FIFO_DEPTH(4)) dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .clk_div (clk_div),
    .wr_en   (wr_en),
    .wr_data (wr_data),
    .full    (full),
    .overflow(overflow),
    .level   (level),
    .busy    (busy),
    .tx      (tx)
  );

  initial forever #5 clk_in = ~clk_in;

  // baud level: 10 cycles high / 10 cycles low, changed on negedges
  initial forever begin
    repeat (10) @(negedge clk_in);
    clk_div = ~clk_div;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Check one full frame; aligned=1 means the previous frame's last stop
  // midpoint was just sampled, so the start bit must follow with no gap.
  task automatic recv(input logic [7:0] b, input bit aligned);
    int t;
    if (!aligned) begin
      t = 0;
      while (tx !== 1'b0 && t < 2000) begin
        @(negedge clk_in);
        t++;
      end
      if (t >= 2000) begin
        chk($sformatf("start_timeout_%02h", b), t, 0);
        return;
      end
      repeat (10) @(negedge clk_in);
    end else begin
      repeat (20) @(negedge clk_in);
    end
    chk($sformatf("start_%02h", b), tx, 0);
    chk($sformatf("busy_%02h", b), busy, 1);
    for (int i = 0; i < 8; i++) begin
      repeat (20) @(negedge clk_in);
      chk($sformatf("d%0d_%02h", i, b), tx, b[i]);
    end
`ifdef BT_UART_TX_PARITY_EN
    repeat (20) @(negedge clk_in);
    chk($sformatf("parity_%02h", b), tx, ^b);
`endif
    for (int s = 0; s < 2; s++) begin
      repeat (20) @(negedge clk_in);
      chk($sformatf("stop%0d_%02h", s, b), tx, 1);
    end
  endtask

  // after the final stop bit ends, the line is idle and the FIFO empty
  task automatic idle_chk(input string tag);
    repeat (12) @(negedge clk_in);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_tx"}, tx, 1);
    chk({tag, "_level"}, level, 0);
  endtask

  task automatic quiet_chk(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_in);
      if (tx !== 1'b1) bad++;
    end
    chk(tag, bad, 0);
  endtask

  task automatic put(input logic [7:0] d);
    @(negedge clk_in);
    wr_en   = 1'b1;
    wr_data = d;
  endtask

  initial begin
    int t;
    reset   = 1'b0;
    wr_en   = 1'b0;
    wr_data = '0;

    // reset state
    repeat (5) @(negedge clk_in);
    chk("rst_tx", tx, 1);
    chk("rst_busy", busy, 0);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_ovf", overflow, 0);
    reset = 1'b1;
    quiet_chk("rst_quiet");
    chk("rst_busy_after", busy, 0);

    // single byte
    put(8'hA5);
    @(negedge clk_in);
    wr_en = 1'b0;
    chk("single_level", level, 1);
    recv(8'hA5, 1'b0);
    idle_chk("single_end");

    // overflow: five writes beginning the cycle after a tick
    @(posedge clk_div);
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk_in);
      if (i == 5) begin
        chk("ovf_level4", level, 4);
        chk("ovf_full4", full, 1);
        chk("ovf_pre", overflow, 0);
      end
      wr_en   = 1'b1;
      wr_data = 8'(i);
    end
    @(negedge clk_in);
    wr_en = 1'b0;
    chk("ovf_level", level, 4);
    chk("ovf_full", full, 1);
    chk("ovf_flag", overflow, 1);
    recv(8'h01, 1'b0);
    recv(8'h02, 1'b1);
    recv(8'h03, 1'b1);
    recv(8'h04, 1'b1);
    idle_chk("ovf_end");
    chk("ovf_sticky", overflow, 1);

    // back-to-back with two stop bits
    put(8'h00);
    put(8'hFF);
    @(negedge clk_in);
    wr_en = 1'b0;
    recv(8'h00, 1'b0);
    recv(8'hFF, 1'b1);
    idle_chk("b2b_end");

    // parity (or stop directly after bit 7 when the feature is off)
    put(8'h07);
    @(negedge clk_in);
    wr_en = 1'b0;
    recv(8'h07, 1'b0);
    idle_chk("par07_end");
    put(8'h03);
    @(negedge clk_in);
    wr_en = 1'b0;
    recv(8'h03, 1'b0);
    idle_chk("par03_end");

    // reset during data bit 3 (0x52 has bit3 = 0) with a second byte queued
    put(8'h52);
    put(8'h3C);
    @(negedge clk_in);
    wr_en = 1'b0;
    t = 0;
    while (tx !== 1'b0 && t < 2000) begin
      @(negedge clk_in);
      t++;
    end
    chk("mid_start_seen", (t < 2000), 1);
    repeat (90) @(negedge clk_in);
    chk("mid_bit3", tx, 0);
    chk("mid_level", level, 1);
    reset = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_level", level, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_ovf", overflow, 0);
    repeat (3) @(negedge clk_in);
    reset = 1'b1;
    quiet_chk("mid_quiet");
    chk("mid_level_after", level, 0);
    chk("mid_busy_after", busy, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
